// File: rtl/cache_ctrl.sv
// Miss-handling controller for a direct-mapped, 4-word-line cache.
// Owns the tag store and sequences victim writeback and line fill over the cache's SDRAM-side port.
`timescale 1ns/1ps
module cache_ctrl #(
  parameter int LINES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        core_req,
  input  logic [15:0] core_addr,
  input  logic        core_write,
  output logic        core_ready,
  output logic        busy,
  input  logic        cache_en,
  output logic [3:0]  cache_wen,
  output logic [13:0] cache_addr,
  output logic [63:0] cache_wdata,
  input  logic [63:0] cache_rdata,
  output logic        mem_req,
  output logic        mem_write,
  output logic [13:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  localparam int IW = $clog2(LINES);

  // Handshakes: mem_req/mem_write/mem_addr/mem_wdata are held until the cycle mem_ack is
  // seen high; mem_rvalid is a single-cycle strobe; a cache port cycle only counts when cache_en is high.
  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_WB_RD, S_WB_CAP, S_WB_REQ,
    S_FILL_REQ, S_FILL_WAIT, S_FILL_WR
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   sweep_q, sweep_d;
  logic [1:0]      victim_q, victim_d;
  logic [63:0]     buf_q, buf_d;
  logic [3:0]      tag_rd_q;
  logic [3:0]      tag_mem [LINES];

  logic            tag_we;
  logic [IW-1:0]   tag_waddr;
  logic [3:0]      tag_wdata;

  logic [IW-1:0]   idx;
  logic            hit;
  logic            victim_dirty;
  logic            sweep_last;
  logic            unused_word_sel;

  assign idx             = core_addr[2 +: IW];
  assign hit             = tag_rd_q[3] && (tag_rd_q[1:0] == core_addr[15:14]);
  assign victim_dirty    = tag_rd_q[3] && tag_rd_q[2];
  assign sweep_last      = (sweep_q == IW'(LINES - 1));
  assign unused_word_sel = ^core_addr[1:0];

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:      if (sweep_last) state_d = S_IDLE;
      S_IDLE:      if (core_req) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit)               state_d = S_IDLE;
        else if (victim_dirty) state_d = S_WB_RD;
        else                   state_d = S_FILL_REQ;
      end
      S_WB_RD:     if (cache_en) state_d = S_WB_CAP;
      S_WB_CAP:    state_d = S_WB_REQ;
      S_WB_REQ:    if (mem_ack) state_d = S_FILL_REQ;
      S_FILL_REQ:  if (mem_ack) state_d = S_FILL_WAIT;
      S_FILL_WAIT: if (mem_rvalid) state_d = S_FILL_WR;
      S_FILL_WR:   if (cache_en) state_d = S_IDLE;
      default:     state_d = S_INIT;
    endcase
  end

  // Output and tag-write decode
  always_comb begin
    core_ready  = 1'b0;
    busy        = 1'b1;
    cache_wen   = 4'h0;
    cache_addr  = 14'h0;
    cache_wdata = 64'h0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = 14'h0;
    mem_wdata   = 64'h0;
    tag_we      = 1'b0;
    tag_waddr   = idx;
    tag_wdata   = 4'h0;
    case (state_q)
      S_INIT: begin
        tag_we    = 1'b1;
        tag_waddr = sweep_q;
      end
      S_IDLE: busy = 1'b0;
      S_LOOKUP: begin
        busy = 1'b0;
        if (hit) begin
          core_ready = 1'b1;
          tag_we     = core_write;
          tag_wdata  = {2'b11, tag_rd_q[1:0]};
        end
      end
      S_WB_RD: cache_addr = {victim_q, core_addr[13:2]};
      S_WB_REQ: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {victim_q, core_addr[13:2]};
        mem_wdata = buf_q;
      end
      S_FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = core_addr[15:2];
      end
      S_FILL_WR: begin
        cache_wen   = 4'hF;
        cache_addr  = core_addr[15:2];
        cache_wdata = buf_q;
        tag_we      = cache_en;
        tag_wdata   = {2'b10, core_addr[15:14]};
      end
      default: ;
    endcase
  end

  // Datapath next values: sweep counter, victim tag, line buffer
  always_comb begin
    sweep_d  = sweep_q;
    victim_d = victim_q;
    buf_d    = buf_q;
    if (state_q == S_INIT)                  sweep_d  = sweep_q + IW'(1);
    if (state_q == S_LOOKUP)                victim_d = tag_rd_q[1:0];
    if (state_q == S_WB_CAP)                buf_d    = cache_rdata;
    if (state_q == S_FILL_WAIT && mem_rvalid) buf_d  = mem_rdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sweep_q  <= '0;
      victim_q <= 2'b00;
      buf_q    <= 64'h0;
    end else begin
      sweep_q  <= sweep_d;
      victim_q <= victim_d;
      buf_q    <= buf_d;
    end
  end

  // Tag store: read every cycle at the core index, so LOOKUP sees the entry IDLE addressed
  always_ff @(posedge clock) begin
    tag_rd_q <= tag_mem[idx];
    if (tag_we) tag_mem[tag_waddr] <= tag_wdata;
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomised scoreboard bench for cache_ctrl with SDRAM and cache RAM environment models.
`timescale 1ns/1ps
module tb_cache_ctrl;
  localparam int LINES = 4096;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        core_req;
  logic [15:0] core_addr;
  logic        core_write;
  logic        core_ready;
  logic        busy;
  logic        cache_en;
  logic [3:0]  cache_wen;
  logic [13:0] cache_addr;
  logic [63:0] cache_wdata;
  logic [63:0] cache_rdata;
  logic        mem_req;
  logic        mem_write;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  always #5 clock = ~clock;

  cache_ctrl #(.LINES(LINES)) dut (
    .clock(clock), .reset_n(reset_n),
    .core_req(core_req), .core_addr(core_addr), .core_write(core_write),
    .core_ready(core_ready), .busy(busy),
    .cache_en(cache_en), .cache_wen(cache_wen), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard queues: {write, line, data}, {line, data}, {write, addr}
  logic [78:0] exp_mem_q[$];
  logic [77:0] exp_fill_q[$];
  logic [16:0] exp_rdy_q[$];

  // Reference model: tag/line state per index and expected SDRAM contents
  logic        m_valid [LINES];
  logic        m_dirty [LINES];
  logic [1:0]  m_tag   [LINES];
  logic [63:0] m_line  [LINES];
  logic [63:0] m_mem   [16384];

  // Environment: SDRAM and cache RAM contents
  logic [63:0] mem_env [16384];
  logic [63:0] cram    [16384];
  logic [63:0] cram_rd = 64'h0;
  logic [15:0] core_wdata_tb = 16'h0;

  int          rand_en    = 0;
  int          stall_mode = 0;
  int          wb_left    = 0;
  int          fill_left  = 0;
  int          late_rv    = -1;
  int          wb_cyc     = 0;
  int          fill_cyc   = 0;
  logic [13:0] watch_addr = 14'h0;
  logic        rd_acked   = 1'b0;

  assign cache_rdata = cram_rd;

  function automatic logic [63:0] mem_init(input int i);
    if (i == 14'h048D) return 64'h0004_0003_0002_0001;
    return {16'(i * 7 + 1), 16'(i * 13 + 2), 16'(i ^ 16'h5A5A), 16'(i + 16'h1000)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Model of one core access: pushes every response the controller must produce
  task automatic model_issue(input logic [15:0] a, input logic w, input logic [15:0] d,
                             output logic hit);
    logic [11:0] ix;
    logic [13:0] vl;
    ix  = a[13:2];
    hit = m_valid[ix] && (m_tag[ix] == a[15:14]);
    if (!hit) begin
      if (m_valid[ix] && m_dirty[ix]) begin
        vl = {m_tag[ix], ix};
        m_mem[vl] = m_line[ix];
        exp_mem_q.push_back({1'b1, vl, m_line[ix]});
      end
      exp_mem_q.push_back({1'b0, a[15:2], 64'h0});
      m_line[ix]  = m_mem[a[15:2]];
      exp_fill_q.push_back({a[15:2], m_line[ix]});
      m_valid[ix] = 1'b1;
      m_dirty[ix] = 1'b0;
      m_tag[ix]   = a[15:14];
    end
    exp_rdy_q.push_back({w, a});
    if (w) begin
      m_line[ix][a[1:0] * 16 +: 16] = d;
      m_dirty[ix] = 1'b1;
    end
  endtask

  task automatic wait_ready(output int lat, output logic got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 3000) begin
      @(negedge clock);
      if (core_ready) got = 1'b1;
      else lat++;
    end
  endtask

  task automatic end_access();
    @(posedge clock); #1;
    core_req = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
  endtask

  // Called at posedge+1 with the controller idle
  task automatic do_access(input logic [15:0] a, input logic w);
    logic hit;
    int   lat;
    logic got;
    core_wdata_tb = 16'($urandom);
    model_issue(a, w, core_wdata_tb, hit);
    core_addr  = a;
    core_write = w;
    core_req   = 1'b1;
    wait_ready(lat, got);
    if (!got)     note_fail("ready_timeout");
    else if (hit) check("hit_latency", lat, 1);
    else          check("miss_latency_min", lat >= 6, 1);
    end_access();
  endtask

  // Cache RAM: port writes on FILL, 1-cycle read latency, core store on core_ready
  always @(posedge clock) begin
    logic [63:0] nv;
    if (cache_en) begin
      if (cache_wen != 4'h0) begin
        nv = cram[cache_addr];
        for (int w = 0; w < 4; w++)
          if (cache_wen[w]) nv[w * 16 +: 16] = cache_wdata[w * 16 +: 16];
        cram[cache_addr] <= nv;
      end else begin
        cram_rd <= cram[cache_addr];
      end
    end
    if (core_ready && core_write) begin
      nv = cram[core_addr[15:2]];
      nv[core_addr[1:0] * 16 +: 16] = core_wdata_tb;
      cram[core_addr[15:2]] <= nv;
    end
  end

  // cache_en driver: random gaps, or scripted stalls in WB_RD / FILL_WR
  initial begin
    cache_en = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (stall_mode != 0) begin
        if (cache_wen == 4'h0 && cache_addr == watch_addr && !mem_req && wb_left > 0) begin
          cache_en = 1'b0;
          wb_left--;
        end else if (cache_wen == 4'hF && fill_left > 0) begin
          cache_en = 1'b0;
          fill_left--;
        end else begin
          cache_en = 1'b1;
        end
      end else begin
        cache_en = (rand_en != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // SDRAM responder and memory-request scoreboard
  initial begin
    int          ack_wait;
    int          rv_cnt;
    logic        rv_pending;
    logic [63:0] rv_data;
    logic [78:0] e;
    for (int i = 0; i < 16384; i++) mem_env[i] = mem_init(i);
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
    ack_wait = 0; rv_cnt = 0; rv_pending = 1'b0; rv_data = 64'h0;
    forever begin
      @(posedge clock); #1;
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      if (rv_pending) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
          rv_pending = 1'b0;
        end else begin
          rv_cnt--;
        end
      end else if (mem_req) begin
        if (ack_wait > 0) begin
          ack_wait--;
        end else begin
          mem_ack  = 1'b1;
          ack_wait = $urandom_range(0, 3);
          if (exp_mem_q.size() == 0) begin
            note_fail("mem_unexpected_req");
          end else begin
            e = exp_mem_q.pop_front();
            check("mem_write", mem_write, e[78]);
            check("mem_addr", mem_addr, e[77:64]);
            if (e[78]) check("mem_wdata", mem_wdata, e[63:0]);
          end
          if (mem_write) begin
            mem_env[mem_addr] = mem_wdata;
          end else begin
            rv_pending = 1'b1;
            rv_cnt     = (late_rv >= 0) ? late_rv : $urandom_range(0, 3);
            rv_data    = mem_env[mem_addr];
            rd_acked   = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: core_ready and cache fill writes against the expected queues
  initial begin
    logic [16:0] r;
    logic [77:0] f;
    forever begin
      @(negedge clock);
      if (core_ready) begin
        if (exp_rdy_q.size() == 0) note_fail("ready_unexpected");
        else begin
          r = exp_rdy_q.pop_front();
          check("ready_access", {core_write, core_addr}, r);
        end
      end
      if (cache_wen != 4'h0) begin
        fill_cyc++;
        if (exp_fill_q.size() == 0) note_fail("fill_unexpected");
        else begin
          f = exp_fill_q[0];
          check("fill_wen", cache_wen, 4'hF);
          check("fill_addr", cache_addr, f[77:64]);
          check("fill_data", cache_wdata, f[63:0]);
          if (cache_en) void'(exp_fill_q.pop_front());
        end
      end
      if (cache_wen == 4'h0 && watch_addr != 14'h0 && cache_addr == watch_addr && !mem_req)
        wb_cyc++;
    end
  end

  initial begin
    logic hit;
    int   cnt;
    int   lat;
    logic got;
    logic seen_rdy;
    logic seen_req;
    logic [15:0] a;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 2'b00; m_line[i] = 64'h0;
    end
    for (int i = 0; i < 16384; i++) m_mem[i] = mem_init(i);

    reset_n = 1'b0; core_req = 1'b0; core_addr = 16'h0; core_write = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_core_ready", core_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_cache_wen", cache_wen, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_addrs", {cache_addr, mem_addr}, 0);
    check("rst_data", {cache_wdata, mem_wdata}, 0);

    // Request held through the init sweep becomes the cold read of 0x1234
    @(posedge clock); #1;
    core_wdata_tb = 16'h0;
    model_issue(16'h1234, 1'b0, 16'h0, hit);
    core_addr = 16'h1234; core_write = 1'b0; core_req = 1'b1;
    reset_n = 1'b1;
    cnt = 0; seen_rdy = 1'b0; seen_req = 1'b0;
    while (cnt < 5000) begin
      @(negedge clock);
      if (!busy) break;
      if (core_ready) seen_rdy = 1'b1;
      if (mem_req) seen_req = 1'b1;
      cnt++;
    end
    check("init_busy_cycles", cnt, LINES);
    check("init_no_ready", seen_rdy, 0);
    check("init_no_mem_req", seen_req, 0);
    wait_ready(lat, got);
    check("cold_read_ready", got, 1);
    end_access();

    do_access(16'h1235, 1'b0);
    do_access(16'h1234, 1'b1);
    do_access(16'h5234, 1'b0);
    do_access(16'h5234, 1'b0);
    do_access(16'h5234, 1'b1);

    // Dirty miss with scripted cache_en stalls
    watch_addr = 14'h148D; wb_left = 5; fill_left = 3; wb_cyc = 0; fill_cyc = 0;
    stall_mode = 1;
    do_access(16'h1234, 1'b0);
    stall_mode = 0;
    watch_addr = 14'h0;
    check("wb_rd_cycles", wb_cyc, 6);
    check("fill_wr_cycles", fill_cyc, 4);
    do_access(16'h1236, 1'b0);

    rand_en = 1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       a = {2'($urandom_range(0, 3)), 12'h48D, 2'($urandom_range(0, 3))};
        1:       a = {2'($urandom_range(0, 3)), 12'h123, 2'($urandom_range(0, 3))};
        default: a = {2'($urandom_range(0, 3)), 12'h000, 2'($urandom_range(0, 3))};
      endcase
      do_access(a, 1'($urandom_range(0, 1)));
    end
    rand_en = 0;
    do_access(16'h1234, 1'b0);

    // Reset while waiting for fill data
    late_rv = 8; rd_acked = 1'b0;
    exp_mem_q.push_back({1'b0, 14'h26AF, 64'h0});
    core_addr = 16'h9ABC; core_write = 1'b0; core_req = 1'b1;
    cnt = 0;
    while (!rd_acked && cnt < 200) begin @(posedge clock); #1; cnt++; end
    check("rst_test_read_acked", rd_acked, 1);
    @(posedge clock); #1;
    reset_n = 1'b0; core_req = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < LINES; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    @(negedge clock);
    check("midrst_mem_req", mem_req, 0);
    check("midrst_busy", busy, 1);
    cnt = 1;
    while (cnt < 5000) begin
      @(negedge clock);
      if (!busy) break;
      if (mem_req || core_ready) note_fail("reinit_activity");
      cnt++;
    end
    check("reinit_busy_cycles", cnt, LINES);
    late_rv = -1;
    @(posedge clock); #1;
    do_access(16'h1234, 1'b0);
    do_access(16'h1234, 1'b0);

    repeat (5) @(posedge clock);
    check("exp_mem_q_empty", exp_mem_q.size(), 0);
    check("exp_fill_q_empty", exp_fill_q.size(), 0);
    check("exp_rdy_q_empty", exp_rdy_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Miss-handling controller for the 4-word-line cache RAM block. Keeps a direct-mapped tag store (valid, dirty, 2-bit tag per line) for the 16-bit word address space. Detects core hits and misses. On a miss it sequences the whole line transfer through the cache's SDRAM-side port: write back the dirty victim, fill from SDRAM, install the tag. Sits between the core load/store unit, the cache RAM's SDRAM port and the SDRAM controller.

## Interface
- LINES, default 4096: number of lines; index = addr[13:2], tag = addr[15:14].
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- core_req  in  1  core access pending; core_addr and core_write are held stable until core_ready.
- core_addr  in  16  word address.
- core_write  in  1  access is a store.
- core_ready  out  1  one-cycle pulse: the line is resident, and the core performs its cache RAM access this cycle.
- busy  out  1  init sweep or miss sequence in progress.
- cache_en  in  1  cache RAM SDRAM-side port is usable this cycle (the cache's sdram_en).
- cache_wen  out  4  per-word write enable into the cache RAM.
- cache_addr  out  14  line address [15:2] to the cache RAM.
- cache_wdata  out  64  line data to the cache RAM; word 0 is in [15:0].
- cache_rdata  in  64  line data from the cache RAM; valid the cycle after a read cycle.
- mem_req  out  1  SDRAM transfer request; held until mem_ack.
- mem_write  out  1  request is a line write.
- mem_addr  out  14  SDRAM line address [15:2].
- mem_wdata  out  64  writeback data; held with mem_req.
- mem_ack  in  1  request accepted; write data consumed in the same cycle.
- mem_rvalid  in  1  read line returned on mem_rdata (single cycle).
- mem_rdata  in  64  fill data.

## Operation
- Tag store: LINES entries × 4 bits {valid, dirty, tag[1:0]}, synchronous read with 1-cycle latency, one write port.
- States:
  - INIT: sweep all indices, clearing each entry.
  - IDLE
  - LOOKUP
  - WB_RD, WB_CAP, WB_REQ
  - FILL_REQ, FILL_WAIT, FILL_WR
- INIT: entered on reset. Writes 4'b0 to index 0..LINES-1, one per cycle, then goes to IDLE. busy=1 throughout. core_req is ignored.
- IDLE:
  - On core_req, read the tag at core_addr[13:2] and go to LOOKUP.
  - With no core_req, stay in IDLE.
- LOOKUP:
  - Hit (valid && tag == core_addr[15:14]): core_ready=1; if core_write, set dirty for the entry. Return to IDLE.
  - Miss with valid && dirty: go to WB_RD.
  - Any other miss: go to FILL_REQ.
- WB_RD: cache_addr = {old tag, index}, cache_wen=0. Advance to WB_CAP only in a cycle with cache_en=1; otherwise stay and retry.
- WB_CAP: latch cache_rdata into the line buffer, then go to WB_REQ.
- WB_REQ: mem_req=1, mem_write=1, mem_addr = {old tag, index}, mem_wdata = buffer. On mem_ack, go to FILL_REQ.
- FILL_REQ: mem_req=1, mem_write=0, mem_addr = core_addr[15:2]. On mem_ack, go to FILL_WAIT.
- FILL_WAIT: on mem_rvalid, latch mem_rdata into the buffer and go to FILL_WR.
- FILL_WR: cache_wen=4'hF, cache_addr = core_addr[15:2], cache_wdata = buffer.
  - Advance only in a cycle with cache_en=1.
  - In that cycle, write the tag entry {1, 0, core_addr[15:14]} and go to IDLE.
  - The core, still holding its request, re-looks-up and hits.
- cache_wen is 0 in every state except FILL_WR.
- mem_req is 0 in every state except WB_REQ and FILL_REQ.
- core_ready is 0 except on a LOOKUP hit.
- busy = 1 in every state other than IDLE and LOOKUP.
- Only one miss is outstanding at a time; a new core_req is not examined until the controller is back in IDLE.

## Timing
- Reset values: core_ready=0, busy=1, cache_wen=0, mem_req=0, mem_write=0. All address and data outputs are 0. State is INIT.
- Reset is sampled every cycle, including mid-miss. An in-flight mem_req drops in the cycle after reset is sampled. The SDRAM controller must discard an unacknowledged request when mem_req falls.
- Init sweep: LINES cycles; busy first reads 0 in cycle LINES+1 after reset release.
- Hit latency: core_req first seen in IDLE in cycle N → core_ready in cycle N+1.
- Clean-miss latency: FILL_REQ at N+2; then mem_ack wait, mem_rvalid wait, and FILL_WR (≥1 cycle); then IDLE, LOOKUP, and core_ready.
- A dirty miss adds WB_RD (≥1) + WB_CAP (1) + WB_REQ (≥1) cycles ahead of the fill.
- cache_en=0 simply extends WB_RD and FILL_WR. Outputs stay stable while stalled.
- mem_ack in the same cycle as mem_req is legal. mem_rvalid is never expected before mem_ack.

## Test plan
- Reset, hold core_req=1 → busy stays 1 for 4096 cycles; no core_ready, no mem_req; then the first lookup runs.
- Cold read at 0x1234 → one mem_req read with mem_addr=0x048D. Return mem_rdata=0x0004_0003_0002_0001 → cache_wen=F at cache_addr=0x048D with that data; then core_ready.
- Repeat the read at 0x1235 → core_ready exactly 1 cycle after IDLE sees the request; no mem_req.
- Write hit at 0x1234, then read 0x5234:
  - Writeback: cache read of 0x048D, then mem write to 0x048D carrying the captured cache_rdata.
  - Fill: mem read at 0x148D.
  - Completion: core_ready; tag for index 0x48D = {1,0,01}.
- Same dirty miss with cache_en held low for 5 cycles in WB_RD and 3 in FILL_WR → each state extended exactly that long; outputs stable; final data correct.
- Assert reset_n=0 during FILL_WAIT → mem_req low and busy=1 next cycle. A late mem_rvalid is ignored. The init sweep restarts, and a previously filled line misses afterwards.
